// File: rtl/seg7_pkg.sv
// Shared constants and types for the 8-digit 7-segment trace display.
// Segment patterns are active-low with bit 0 = segment CA.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_NONE   = 8'hFF;

    typedef logic [2:0] digit_idx_t;

    localparam logic [6:0] HEX2SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_trace_display_if.sv
// Trace-in / display-out bundle. The master side supplies the CPU trace and raw controls;
// the slave side (the display block) drives the anodes, segments and mode flag.
interface seg7_trace_display_if;

    logic [31:0] pc;
    logic [31:0] inst;
    logic        sel_btn;
    logic        freeze;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        show_inst;

    modport master (
        output pc, inst, sel_btn, freeze,
        input  an, seg, dp, show_inst
    );

    modport slave (
        input  pc, inst, sel_btn, freeze,
        output an, seg, dp, show_inst
    );

endinterface

// File: rtl/seg7_debounce.sv
// Two-flop synchroniser followed by a stable-time debouncer for one raw switch/button.
// rise pulses for one cycle on the cycle level goes 0 -> 1.
module seg7_debounce #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic clk_in,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int DB_CYC = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int CW     = $clog2(DB_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Counter tracks how long the synchronised input has disagreed with level.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                rise  <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/seg7_trace_display.sv
// Multiplexed 8-digit hex display of the CPU pc/inst trace with mode toggle and freeze snapshot.
// Optional SEG7_HEARTBEAT_EN: digit-0 decimal point blinks whenever the captured pc changes.
module seg7_trace_display
    import seg7_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int DEBOUNCE_MS = 10,
    parameter int BLANK_CYC   = 2
) (
    input  logic                 clk_in,
    input  logic                 reset,
    seg7_trace_display_if.slave  bus
);

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int PW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYC);

    logic          sel_level, sel_rise;
    logic          frz_level, frz_rise;
    logic          unused_ok;

    logic          show_inst_q;
    logic [31:0]   cap_pc, cap_inst;
    logic [PW-1:0] pre, pre_nxt;
    digit_idx_t    idx, idx_nxt;
    logic [31:0]   disp;
    logic [3:0]    nib;
    logic [7:0]    an_q, an_nxt;
    logic [6:0]    seg_q, seg_nxt;
    logic          dp_q, dp_nxt;

    seg7_debounce #(.CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_sel_db (
        .clk_in (clk_in),
        .reset  (reset),
        .raw    (bus.sel_btn),
        .level  (sel_level),
        .rise   (sel_rise)
    );

    seg7_debounce #(.CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_frz_db (
        .clk_in (clk_in),
        .reset  (reset),
        .raw    (bus.freeze),
        .level  (frz_level),
        .rise   (frz_rise)
    );

    assign unused_ok = &{1'b0, sel_level, frz_rise};

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            show_inst_q <= 1'b0;
            cap_pc      <= '0;
            cap_inst    <= '0;
            pre         <= '0;
            idx         <= '0;
            an_q        <= AN_NONE;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            if (sel_rise) show_inst_q <= ~show_inst_q;
            if (!frz_level) begin
                cap_pc   <= bus.pc;
                cap_inst <= bus.inst;
            end
            pre   <= pre_nxt;
            idx   <= idx_nxt;
            an_q  <= an_nxt;
            seg_q <= seg_nxt;
            dp_q  <= dp_nxt;
        end
    end

`ifdef SEG7_HEARTBEAT_EN
    logic        hb;
    logic [31:0] cap_pc_prev;

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            hb          <= 1'b0;
            cap_pc_prev <= '0;
        end else begin
            cap_pc_prev <= cap_pc;
            if (cap_pc != cap_pc_prev) hb <= ~hb;
        end
    end
`endif

    // Outputs are registered from the next scan position so an/seg/dp line up with idx/pre.
    always_comb begin
        pre_nxt = (pre == PRE_LAST) ? '0 : pre + PW'(1);
        idx_nxt = (pre == PRE_LAST) ? idx + 3'd1 : idx;
        disp    = show_inst_q ? cap_inst : cap_pc;
        nib     = disp[{idx_nxt, 2'b00} +: 4];
        seg_nxt = HEX2SEG[nib];
        an_nxt  = AN_NONE;
        if (pre_nxt >= PRE_BLANK) an_nxt[idx_nxt] = 1'b0;
        dp_nxt  = 1'b1;
        if (idx_nxt == 3'd7 && frz_level) dp_nxt = 1'b0;
`ifdef SEG7_HEARTBEAT_EN
        if (idx_nxt == 3'd0) dp_nxt = ~hb;
`endif
    end

    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.show_inst = show_inst_q;

endmodule
